// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Brief    : Shared constants for the fetch unit: opcode, field map, FSM codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

    localparam int c_instr_w = 16;

    // Instruction field bit positions
    localparam int c_opc_msb  = 15;
    localparam int c_opc_lsb  = 13;
    localparam int c_srca_msb = 12;
    localparam int c_srca_lsb = 10;
    localparam int c_srcb_msb = 9;
    localparam int c_srcb_lsb = 7;
    localparam int c_dest_msb = 6;
    localparam int c_dest_lsb = 4;

    localparam logic [2:0] c_op_halt = 3'b111;

    localparam int         c_st_w      = 2;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_fetch  = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    function automatic logic [2:0] get_opcode(input logic [c_instr_w-1:0] ins);
        return ins[c_opc_msb:c_opc_lsb];
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Instruction stream handshake from the fetch unit to its consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic [c_instr_w-1:0] instruction;
    logic                 instr_valid;
    logic [ADDR_W-1:0]    instr_pc;
    logic                 instr_ready;

    modport master (
        output instruction,
        output instr_valid,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        input  instr_pc,
        output instr_ready
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through FIFO with flush; empty head reads as zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     flush,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          valid,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int           c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr;
    logic [c_aw-1:0]  r_rd;
    logic [c_aw:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push
    assign w_pop_ok  = pop && (r_count != '0);
    assign w_push_ok = push && ((r_count != c_full) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid = (r_count != '0);
    assign dout  = valid ? r_mem[r_rd] : '0;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Loadable instruction memory, PC and prefetch FIFO with redirect/HALT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          load_en,
    input  wire logic [ADDR_W-1:0]             load_addr,
    input  wire logic [c_instr_w-1:0]          load_data,
    input  wire logic                          fetch_en,
    input  wire logic                          redirect_valid,
    input  wire logic [ADDR_W-1:0]             redirect_pc,
    output logic                               halted,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    instr_fetch_unit_if.master                 fetch_if
);
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_entry_w = ADDR_W + c_instr_w;
    localparam int c_mem_d   = 1 << ADDR_W;

    logic [c_instr_w-1:0] r_mem [c_mem_d];
    logic [c_st_w-1:0]    r_state;
    logic [c_st_w-1:0]    w_state_next;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_rpc;
    logic [c_instr_w-1:0] r_rdata;
    logic                 r_inflight;

    logic                 w_halted;
    logic                 w_fetch_ok;
    logic                 w_load_ok;
    logic                 w_halt_ret;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_room;
    logic [c_cnt_w:0]     w_occupancy;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_valid;
    logic [c_entry_w-1:0] w_head;

    // Redirect cancels the returning word, so it can neither be pushed nor halt
    assign w_halt_ret  = r_inflight && !redirect_valid && (get_opcode(r_rdata) == c_op_halt);
    assign w_push      = r_inflight && !redirect_valid;
    assign w_pop       = w_valid && fetch_if.instr_ready && !redirect_valid;
    assign w_occupancy = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_room      = w_occupancy < (c_cnt_w+1)'(FIFO_DEPTH);
    assign w_issue     = w_fetch_ok && fetch_en && !redirect_valid && !w_halt_ret && w_room;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_halt_ret)    w_state_next = c_st_halted;
                else if (fetch_en) w_state_next = c_st_fetch;
            end
            c_st_fetch: begin
                if (w_halt_ret)     w_state_next = c_st_halted;
                else if (!fetch_en) w_state_next = c_st_idle;
            end
            c_st_halted: begin
                if (redirect_valid) w_state_next = fetch_en ? c_st_fetch : c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_halted   = 1'b0;
        w_fetch_ok = 1'b0;
        w_load_ok  = 1'b0;
        case (r_state)
            c_st_idle:   begin w_fetch_ok = 1'b1; w_load_ok = load_en; end
            c_st_fetch:  begin w_fetch_ok = 1'b1; end
            c_st_halted: begin w_halted   = 1'b1; w_load_ok = load_en; end
            default:     begin w_fetch_ok = 1'b0; end
        endcase
    end

    // Memory is deliberately outside reset so loaded programs survive it
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
        if (w_issue) begin
            r_rdata <= r_mem[r_pc];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= '0;
            r_rpc      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rpc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({r_rpc, r_rdata}),
        .dout  (w_head),
        .valid (w_valid),
        .count (w_count)
    );

    assign fetch_if.instruction = w_head[c_instr_w-1:0];
    assign fetch_if.instr_pc    = w_head[c_entry_w-1:c_instr_w];
    assign fetch_if.instr_valid = w_valid;
    assign halted               = w_halted;
    assign fifo_count           = w_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Scoreboard bench for instr_fetch_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = 8'h00;
    logic [15:0] load_data = 16'h0000;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halted;
    logic [2:0]  fifo_count;

    instr_fetch_unit_if #(.ADDR_W(8)) fif ();

    instr_fetch_unit #(
        .ADDR_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fifo_count     (fifo_count),
        .fetch_if       (fif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ins;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    logic [15:0] prog [5] = '{16'h0A20, 16'h2E40, 16'h5710, 16'h7C00, 16'hE000};
    logic [15:0] prog20 [5] = '{16'h3A50, 16'h4B60, 16'h6C70, 16'h1D80, 16'hE000};

    // Monitor: every accepted handshake must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en && reset && fif.instr_valid && fif.instr_ready && !redirect_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_item: got pc=%h instr=%h, required no item", fif.instr_pc, fif.instruction);
            end else begin
                mon_e = sb.pop_front();
                if (fif.instr_pc !== mon_e.pc || fif.instruction !== mon_e.ins ||
                    (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    fails++;
                    $display("FAIL stream_item: got pc=%h instr=%h cyc=%0d, required pc=%h instr=%h cyc=%0d",
                             fif.instr_pc, fif.instruction, cyc, mon_e.pc, mon_e.ins, mon_e.cyc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic exp_item(input logic [7:0] pc, input logic [15:0] ins, input int c);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d items outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic redirect(input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(fif.instr_valid), 32'h0);
        chk({tag, "_instr"}, 32'(fif.instruction), 32'h0);
        chk({tag, "_pc"},    32'(fif.instr_pc),    32'h0);
        chk({tag, "_halted"}, 32'(halted),         32'h0);
        chk({tag, "_count"}, 32'(fifo_count),      32'h0);
    endtask

    initial begin
        int c0;
        int n;
        fif.instr_ready = 1'b0;

        step(3);
        chk_reset_outputs("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < 5; i++) load(8'(i), prog[i]);
        for (int i = 0; i < 5; i++) load(8'(8'h20 + i), prog20[i]);
        load(8'hFE, 16'h2222);
        load(8'hFF, 16'h4444);
        load(8'h40, 16'h1111);
        load(8'h41, 16'hE000);

        // Streaming from cold start
        mon_en = 1'b1;
        fif.instr_ready = 1'b1;
        fetch_en = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 5; i++) exp_item(8'(i), prog[i], c0 + 2 + i);
        drain(20);
        chk("stream_halted", 32'(halted), 32'h1);
        chk("stream_valid_after_halt", 32'(fif.instr_valid), 32'h0);

        // Backpressure, with a load attempt while fetching
        fif.instr_ready = 1'b0;
        redirect(8'h00);
        step(5);
        load(8'h40, 16'h5555);
        step(4);
        chk("bp_count", 32'(fifo_count), 32'h4);
        chk("bp_valid", 32'(fif.instr_valid), 32'h1);
        chk("bp_head_pc", 32'(fif.instr_pc), 32'h0);
        chk("bp_head_instr", 32'(fif.instruction), 32'h0A20);
        for (int i = 0; i < 5; i++) exp_item(8'(i), prog[i], -1);
        fif.instr_ready = 1'b1;
        drain(20);
        step(3);
        chk("bp_halted", 32'(halted), 32'h1);
        chk("bp_count_end", 32'(fifo_count), 32'h0);

        // Load during FETCH must have been dropped
        c0 = cyc;
        exp_item(8'h40, 16'h1111, c0 + 3);
        exp_item(8'h41, 16'hE000, c0 + 4);
        redirect(8'h40);
        drain(20);

        // Load while HALTED takes effect
        load(8'h40, 16'h5555);
        c0 = cyc;
        exp_item(8'h40, 16'h5555, c0 + 3);
        exp_item(8'h41, 16'hE000, c0 + 4);
        redirect(8'h40);
        drain(20);

        // Redirect with 3 queued entries and a simultaneous pop
        fif.instr_ready = 1'b0;
        redirect(8'h00);
        n = 0;
        while (fifo_count != 3'd3 && n < 10) begin
            step();
            n++;
        end
        chk("pre_redirect_count", 32'(fifo_count), 32'h3);
        c0 = cyc;
        for (int i = 0; i < 5; i++) exp_item(8'(8'h20 + i), prog20[i], c0 + 3 + i);
        fif.instr_ready = 1'b1;
        redirect(8'h20);
        chk("flush_count", 32'(fifo_count), 32'h0);
        chk("flush_valid", 32'(fif.instr_valid), 32'h0);
        drain(20);

        // PC wrap
        c0 = cyc;
        exp_item(8'hFE, 16'h2222, c0 + 3);
        exp_item(8'hFF, 16'h4444, c0 + 4);
        for (int i = 0; i < 5; i++) exp_item(8'(i), prog[i], c0 + 5 + i);
        redirect(8'hFE);
        drain(20);

        // Reset in the middle of a stream
        fif.instr_ready = 1'b0;
        redirect(8'h00);
        step(3);
        reset = 1'b0;
        step();
        chk_reset_outputs("midreset");
        reset = 1'b1;
        fif.instr_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 5; i++) exp_item(8'(i), prog[i], c0 + 2 + i);
        drain(20);
        step(2);
        chk("midreset_halted", 32'(halted), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage for `InOrderProcessor`. It holds a loadable instruction memory and a program counter, and prefetches 16-bit instructions into a small FIFO. It presents them one per cycle on a valid/ready handshake whose `instruction` output drives the processor's `instruction` input directly. It supports front-end redirect (jump/flush) and stops on a HALT opcode.

## Interface
- `ADDR_W`, 8: PC / instruction-memory address width; memory depth is 2^ADDR_W words.
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge, asserted when 0.
- `load_en` input 1: instruction-memory write strobe.
- `load_addr` input ADDR_W: write address.
- `load_data` input 16: write data.
- `fetch_en` input 1: permits issuing new memory reads.
- `redirect_valid` input 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` input ADDR_W: new PC.
- `instr_ready` input 1: consumer accepts the head entry (tie to 1 for `InOrderProcessor`).
- `instruction` output 16: head instruction; format is opcode[15:13], srcA[12:10], srcB[9:7], dest[6:4], unused[3:0].
- `instr_valid` output 1: `instruction` and `instr_pc` are meaningful.
- `instr_pc` output ADDR_W: address the head instruction was fetched from.
- `halted` output 1: HALT has been fetched and issue has stopped.
- `fifo_count` output clog2(FIFO_DEPTH)+1: occupied entries.

## Operation
- Reset (`reset`=0):
  - PC=0, FIFO empty, in-flight cleared, state IDLE.
  - Outputs: `instr_valid`=0, `instruction`=16'h0000, `instr_pc`=0, `halted`=0, `fifo_count`=0.
  - Memory contents are not cleared.
- States:
  - IDLE → FETCH when `fetch_en`=1.
  - FETCH → IDLE when `fetch_en`=0.
  - FETCH → HALTED when a read returns opcode 3'b111 (HALT).
  - HALTED → FETCH on `redirect_valid`=1 with `fetch_en`=1; → IDLE on `redirect_valid` with `fetch_en`=0.
- Issue: in FETCH, read mem[PC] and PC←PC+1 mod 2^ADDR_W when count + inflight < FIFO_DEPTH. At most one read is in flight.
- Return: the read data is pushed the next cycle together with its PC. The HALT word itself is enqueued and delivered. Nothing after it is issued, and any in-flight word behind it is discarded.
- Pop: when `instr_valid`&&`instr_ready`. Push and pop may occur in the same cycle; count is unchanged and the FIFO is never full-blocked in that case.
- Empty FIFO: `instr_valid`=0, `instruction`=16'h0000.
- Redirect:
  - The FIFO is flushed, the in-flight read is discarded, PC←`redirect_pc`, and `halted` clears. It has priority over push and pop in the same cycle; a simultaneous pop is not counted as a handshake.
  - In IDLE, only PC and the flush take effect.
- Load:
  - Honoured only in IDLE or HALTED; ignored in FETCH.
  - A write to the address being read in the same cycle returns the old data.
- `fetch_en` falling: an in-flight read still completes and is pushed; the FIFO keeps draining.

## Timing
- Memory read is synchronous, 1 cycle. The FIFO is first-word-fall-through with registered outputs.
- Cold start latency: `fetch_en` high at edge N (FIFO empty) → read at N → push at N+1 → `instr_valid`=1 after edge N+1, so the instruction is visible in cycle N+2.
- Steady state: one instruction per cycle when `instr_ready`=1.
- Redirect latency: `redirect_valid` at edge R → the first new-target instruction is valid 2 cycles after R.
- `halted` rises in the same cycle the HALT word is pushed.
- Full FIFO with `instr_ready`=0: no issue; PC holds.
- PC wrap: PC=2^ADDR_W−1 is fetched, then PC=0.

## Structure
- Shared package: `OP_HALT`=3'b111, the instruction field bit positions, and the state encoding (IDLE/FETCH/HALTED).
- One sub-module, `sync_fifo`: parameterised width/depth, FWFT, with `flush`, `push`, `pop`, `count`. Each entry is {pc, instruction}.
- Memory and FSM live in `instr_fetch_unit`.

## Test plan
- Streaming: load mem[0..3] = {16'h0A20, 16'h2E40, 16'h5710, 16'h7C00}, mem[4] = 16'hE000.
  - Stimulus: `fetch_en`=1, `instr_ready`=1.
  - Required: those 5 words appear with pc 0..4 on consecutive cycles starting 2 cycles after enable, then `halted`=1 and `instr_valid`=0.
- Backpressure:
  - Stimulus: `instr_ready`=0 for 10 cycles.
  - Required: `fifo_count` saturates at 4, PC stops at 4, the head stays at pc 0, and no word is lost or duplicated after release.
- Redirect:
  - Stimulus: `redirect_valid` with `redirect_pc`=8'h20 while 3 entries are queued and a pop occurs in the same cycle.
  - Required: FIFO flushed, the next valid instruction is mem[0x20] with pc 0x20, 2 cycles later.
- Wrap: redirect to 8'hFE, then check that the pc sequence is FE, FF, 00, 01.
- Reset mid-stream:
  - Stimulus: `reset`=0 for 1 cycle during streaming.
  - Required: all outputs return to their reset values on the next edge, and memory contents persist.
- Load gating:
  - Stimulus: `load_en` during FETCH.
  - Required: memory unchanged.
  - Stimulus: the same write in HALTED.
  - Required: written, and read back correctly after a redirect to that address.
